// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter:
// FSM state encoding, STATUS bit positions and register offsets.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int BUSY    = 0;
  localparam int FULL    = 1;
  localparam int EMPTY   = 2;
  localparam int OVF     = 3;
  localparam int CNT_LSB = 4;

  localparam logic [31:0] DATA_OFS   = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory port as seen by the UART: store strobe, address and data
// from the core; hit and read data back to the core's load mux.
interface mmio_uart_tx_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        hit;
  logic [31:0] rdata;

  // Store semantics: a store is taken on any posedge where memwrite is high;
  // there is no ready/backpressure, so hit/rdata are purely combinational.
  modport master (output memwrite, dataadr, writedata, input hit, rdata);
  modport slave  (input memwrite, dataadr, writedata, output hit, rdata);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wptr - rptr;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA register pushes bytes into a FIFO,
// STATUS register reports busy/full/empty/overflow/count.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int          CLK_DIV    = 868,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0080,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  mmio_uart_tx_if.slave  bus,
  output logic           txd,
  output logic           irq
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          ovf;

  logic          hit;
  logic          sel_status;
  logic          sel_data;
  logic          push;
  logic          pop;
  logic          ovf_clr;
  logic          period_end;
  logic [7:0]    head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] count;
  logic [31:0]   status;
  logic          unused;

  assign hit        = (bus.dataadr[31:3] == BASE_ADDR[31:3]);
  assign sel_status = (bus.dataadr[2] == STATUS_OFS[2]);
  assign sel_data   = (bus.dataadr[2] == DATA_OFS[2]);
  assign push       = bus.memwrite && hit && sel_data;
  assign ovf_clr    = bus.memwrite && hit && sel_status && bus.writedata[OVF];
  assign pop        = (state == IDLE) && !fifo_empty;
  assign period_end = (baud == BW'(CLK_DIV - 1));
  assign unused     = ^{bus.dataadr[1:0], bus.writedata[31:8]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.writedata[7:0]),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_comb begin
    status                 = '0;
    status[BUSY]           = (state != IDLE);
    status[FULL]           = fifo_full;
    status[EMPTY]          = fifo_empty;
    status[OVF]            = ovf;
    status[CNT_LSB +: 5]   = 5'(count);
  end

  assign bus.hit   = hit;
  assign bus.rdata = sel_status ? status : 32'd0;

  // Overflow is sticky: only a STATUS write with bit 3 set clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // txd is registered from the current state, so the line lags the state by
  // one cycle; every state still holds the line for exactly CLK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
      irq     <= 1'b1;
    end else begin
      irq  <= fifo_empty && (state == IDLE);
      baud <= (state == IDLE || period_end) ? '0 : baud + 1'b1;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (!fifo_empty) begin
            shift <= head;
            state <= START;
          end
        end
        START: begin
          txd <= 1'b0;
          if (period_end) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          txd <= shift[0];
          if (period_end) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          txd <= 1'b1;
          if (period_end) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a frame-level reference model (byte queue plus
// cycles-into-frame counter) predicts txd, irq and STATUS every cycle.
module tb_mmio_uart_tx;

  localparam int          CLK_DIV = 4;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] BASE    = 32'h0000_0080;
  localparam int          FRAME   = 10 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd;
  logic irq;

  int checks = 0;
  int errors = 0;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .txd (txd),
    .irq (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];       // bytes accepted but not yet started
  bit         ovf_m  = 1'b0;
  int         k_m    = 1000;  // edges since the current frame's byte was popped
  logic [7:0] cur_m  = 8'h00;
  logic       irq_m  = 1'b1;
  logic       txd_m  = 1'b1;
  bit         busy_pre;
  bit         hit_m;

  function automatic logic frame_bit(int k);
    int b;
    if (k < 1 || k > FRAME) return 1'b1;
    b = (k - 1) / CLK_DIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur_m[b-1];
  endfunction

  function automatic logic [31:0] status_m();
    logic [31:0] s;
    s      = 32'd0;
    s[0]   = (k_m < FRAME);
    s[1]   = (exp_q.size() == DEPTH);
    s[2]   = (exp_q.size() == 0);
    s[3]   = ovf_m;
    s[8:4] = 5'(exp_q.size());
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      ovf_m = 1'b0;
      k_m   = 1000;
      irq_m = 1'b1;
      txd_m = 1'b1;
    end else begin
      busy_pre = (k_m < FRAME);
      hit_m    = ((bus.dataadr >> 3) == (BASE >> 3));
      irq_m    = (exp_q.size() == 0) && !busy_pre;
      if (!busy_pre && exp_q.size() != 0) begin
        cur_m = exp_q.pop_front();
        k_m   = 0;
      end else if (k_m < 1000) begin
        k_m++;
      end
      if (bus.memwrite && hit_m && !bus.dataadr[2]) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(bus.writedata[7:0]);
        else ovf_m = 1'b1;
      end
      if (bus.memwrite && hit_m && bus.dataadr[2] && bus.writedata[3]) ovf_m = 1'b0;
      txd_m = frame_bit(k_m);
    end
  end

  // continuous line/irq scoreboard against the model
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (txd !== txd_m) begin
        errors++;
        $display("FAIL txd_line t=%0t got %b exp %b", $time, txd, txd_m);
      end
      checks++;
      if (irq !== irq_m) begin
        errors++;
        $display("FAIL irq_line t=%0t got %b exp %b", $time, irq, irq_m);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    bus.memwrite  = 1'b1;
    bus.dataadr   = addr;
    bus.writedata = data;
    @(negedge clk);
    bus.memwrite  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || k_m < FRAME + 2) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout got %0d cycles exp < %0d", n, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    bus.dataadr = BASE + 4;
    #1;
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", txd); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL reset_irq got %b exp 1", irq); end
    checks++;
    if (bus.rdata !== 32'h4) begin errors++; $display("FAIL reset_status got %h exp 00000004", bus.rdata); end
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [9:0] pat;
    pat = {1'b1, 8'h55, 1'b0};
    store(BASE, 32'hFFFF_FF55);
    @(negedge clk);
    bus.dataadr = BASE + 4;
    #1;
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL single_pre_start got %b exp 1", txd); end
    checks++;
    if (bus.rdata[0] !== 1'b1) begin errors++; $display("FAIL single_busy_start got %b exp 1", bus.rdata[0]); end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (txd !== pat[i / CLK_DIV]) begin
        errors++;
        $display("FAIL single_bit%0d got %b exp %b", i, txd, pat[i / CLK_DIV]);
      end
      if (i < FRAME - 1) begin
        checks++;
        if (bus.rdata[0] !== 1'b1) begin errors++; $display("FAIL single_busy%0d got 0 exp 1", i); end
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL single_irq_after got %b exp 1", irq); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 6; i++) store(BASE, {$urandom_range(0, 32'hFF_FFFF), 8'(i)});
    bus.dataadr = BASE + 4;
    #1;
    checks++;
    if (bus.rdata !== 32'h4B) begin errors++; $display("FAIL ovf_status got %h exp 0000004b", bus.rdata); end
    store(BASE + 4, $urandom & ~32'h8);
    bus.dataadr = BASE + 4;
    #1;
    checks++;
    if (bus.rdata !== 32'h4B) begin errors++; $display("FAIL ovf_keep got %h exp 0000004b", bus.rdata); end
    store(BASE + 4, 32'h8);
    bus.dataadr = BASE + 4;
    #1;
    checks++;
    if (bus.rdata !== 32'h43) begin errors++; $display("FAIL ovf_clear got %h exp 00000043", bus.rdata); end
    checks++;
    if (bus.rdata !== status_m()) begin errors++; $display("FAIL ovf_model got %h exp %h", bus.rdata, status_m()); end
    wait_idle(6 * (FRAME + 1) + 20);
  endtask

  task automatic test_push_pop_full();
    int n = 0;
    for (int i = 0; i < 5; i++) store(BASE, 32'h10 + i);
    while (!(k_m == FRAME && exp_q.size() == DEPTH) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL pp_timeout got %0d exp < 200", n); end
    store(BASE, 32'h15);
    bus.dataadr = BASE + 4;
    #1;
    checks++;
    if (bus.rdata !== 32'h43) begin errors++; $display("FAIL pp_status got %h exp 00000043", bus.rdata); end
    wait_idle(6 * (FRAME + 1) + 20);
  endtask

  task automatic test_decode();
    store(BASE + 8, 32'h77);
    store(BASE - 4, 32'h66);
    bus.dataadr = BASE + 8;
    #1;
    checks++;
    if (bus.hit !== 1'b0) begin errors++; $display("FAIL dec_hit_88 got %b exp 0", bus.hit); end
    bus.dataadr = BASE - 4;
    #1;
    checks++;
    if (bus.hit !== 1'b0) begin errors++; $display("FAIL dec_hit_7c got %b exp 0", bus.hit); end
    bus.dataadr = BASE + 6;
    #1;
    checks++;
    if (bus.hit !== 1'b1 || bus.rdata !== 32'h4) begin
      errors++; $display("FAIL dec_status got hit %b rdata %h exp hit 1 rdata 00000004", bus.hit, bus.rdata);
    end
    bus.dataadr = BASE + 3;
    #1;
    checks++;
    if (bus.hit !== 1'b1 || bus.rdata !== 32'h0) begin
      errors++; $display("FAIL dec_data got hit %b rdata %h exp hit 1 rdata 00000000", bus.hit, bus.rdata);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      bus.memwrite  = 1'b0;
      bus.writedata = $urandom;
      if (r < 3) begin
        bus.memwrite = 1'b1;
        bus.dataadr  = BASE + $urandom_range(0, 3);
      end else if (r == 3) begin
        bus.memwrite = 1'b1;
        bus.dataadr  = BASE + 4 + $urandom_range(0, 3);
      end else if (r == 4) begin
        bus.memwrite = 1'b1;
        bus.dataadr  = ($urandom_range(0, 1) != 0) ? BASE + 8 : BASE - 4;
      end else begin
        bus.dataadr = BASE + $urandom_range(0, 7);
        #1;
        checks++;
        if (bus.hit !== 1'b1 || bus.rdata !== (bus.dataadr[2] ? status_m() : 32'd0)) begin
          errors++;
          $display("FAIL rand_read%0d adr %h got %h exp %h", i, bus.dataadr, bus.rdata,
                   bus.dataadr[2] ? status_m() : 32'd0);
        end
      end
      @(negedge clk);
    end
    bus.memwrite = 1'b0;
    wait_idle(8 * (FRAME + 1) + 20);
  endtask

  task automatic test_reset_mid_frame();
    store(BASE, 32'hA5);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL midrst_txd got %b exp 1", txd); end
    @(negedge clk);
    bus.dataadr = BASE + 4;
    #1;
    checks++;
    if (bus.rdata !== 32'h4) begin errors++; $display("FAIL midrst_status got %h exp 00000004", bus.rdata); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL midrst_irq got %b exp 1", irq); end
    repeat (2 * FRAME) @(negedge clk);
  endtask

  initial begin
    bus.memwrite  = 1'b0;
    bus.dataadr   = 32'd0;
    bus.writedata = 32'd0;
    test_reset();
    test_single_byte();
    test_overflow();
    test_push_pop_full();
    test_decode();
    test_random();
    test_reset_mid_frame();
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the CPU data-memory port, alongside data_mem. Decodes dataadr/memwrite/writedata from the mips core. Buffers store bytes in a small FIFO and serialises them 8N1 on txd. Returns a status word for the core's load path to mux against data_mem readdata.

Parameters:
CLK_DIV, 868, clk cycles per UART bit (>=2); 100 MHz / 115200.
BASE_ADDR, 32'h0000_0080, word-aligned base; DATA reg at BASE_ADDR, STATUS reg at BASE_ADDR+4.
FIFO_DEPTH, 4, byte entries; power of 2, 2..16.

Ports:
clk  input  1  system clock, posedge.
rst  input  1  synchronous reset, active-high.
memwrite  input  1  store strobe from core.
dataadr  input  32  byte address from core.
writedata  input  32  store data from core.
hit  output  1  combinational: dataadr[31:3]==BASE_ADDR[31:3]; core selects rdata over readdata.
rdata  output  32  combinational read data, valid whenever hit.
txd  output  1  serial out, idle high.
irq  output  1  registered: high while FIFO empty and shifter idle.

Behaviour:
- Reset, synchronous, effective at the next posedge:
  - FIFO empty; count=0; overflow=0.
  - State IDLE; baud counter and bit index 0.
  - txd=1; irq=1.
  - Reset asserted mid-frame aborts the frame; txd=1 from the first cycle after the reset edge.
- Address decode: dataadr[2]=0 selects DATA, dataadr[2]=1 selects STATUS; dataadr[1:0] ignored.
- Push:
  - Condition: memwrite && hit && DATA selected, at posedge.
  - Pushes writedata[7:0]; upper bits ignored.
  - Full and no pop this cycle: byte dropped, overflow set (sticky).
  - Full with a pop this cycle: push accepted, count unchanged.
- STATUS write: memwrite && hit && STATUS selected with writedata[3]=1 clears overflow. Other bits are ignored.
- STATUS read (rdata when STATUS selected):
  - [0] busy (state!=IDLE)
  - [1] full
  - [2] empty
  - [3] overflow
  - [8:4] count
  - rest 0.
- DATA read returns 0.
- FSM, one state per bit period of CLK_DIV cycles:
  - IDLE: txd=1. If FIFO non-empty: pop the head into the shift register, go to START, reset the baud counter. The pop happens in the same cycle.
  - START: txd=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] (LSB first), CLK_DIV cycles per bit. On each period end, shift right and increment the bit index. After bit 7, go to STOP.
  - STOP: txd=1 for CLK_DIV cycles, then go to IDLE.
- Back-to-back frames: IDLE lasts exactly 1 cycle when the FIFO is non-empty, so frame pitch is 10*CLK_DIV+1 cycles.
- Latency: push at edge N (FIFO empty, IDLE) → START entered at edge N+1 → txd=0 from edge N+2.
- Baud counter counts 0..CLK_DIV-1, wraps to 0, and the period-end pulse fires at CLK_DIV-1. Width is $clog2(CLK_DIV).
- FIFO: read/write pointers with an extra wrap bit, depth FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1. Pointers wrap modulo 2*FIFO_DEPTH.
- irq = empty && state==IDLE, registered; one-cycle lag.
- txd is driven from a flop (glitch-free).

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP} (2-bit)
  - STATUS bit-index constants (BUSY=0, FULL=1, EMPTY=2, OVF=3, CNT_LSB=4)
  - register offsets (DATA_OFS=0, STATUS_OFS=4)
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count). The FSM and decode stay in mmio_uart_tx.

Test Plan:
- Reset mid-frame: CLK_DIV=4, write 8'hA5, assert rst at cycle 15 → txd=1 from the next cycle, STATUS=32'h4 (empty), irq=1 two cycles after rst releases.
- Single byte: CLK_DIV=4, store 32'hFFFF_FF55 to 0x80 → txd sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. Start bit first seen 2 cycles after the store edge. busy=1 throughout; irq returns to 1 after the stop bit.
- FIFO full/overflow: FIFO_DEPTH=4, 6 consecutive stores to 0x80 with bytes 0x01..0x06 → first pops immediately, 4 buffered, 6th dropped. STATUS reads full=1, ovf=1, count=4. txd carries 0x01..0x05 only, pitch 41 cycles.
- Overflow clear: store 32'h8 to 0x84 → STATUS[3]=0 next cycle; other STATUS bits unchanged. Store 32'h0 to 0x84 → overflow stays set.
- Push/pop same cycle at full: fill to 4 entries, time a store to the IDLE pop cycle → accepted, count stays 4, ovf=0.
- Decode: store to 0x88 or 0x7C → no push, hit=0. Load from 0x84 → hit=1, rdata=STATUS. Load from 0x80 → rdata=0.
